// File: rtl/mem_stall_ctrl_pkg.sv
// rtl/mem_stall_ctrl_pkg.sv - shared pipeline encodings for the memory stall controller
package mem_stall_ctrl_pkg;

  // Controller state encoding, kept as plain constants for legacy tools
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_D_WAIT = 2'd1;
  localparam logic [1:0] ST_D_DONE = 2'd2;
  localparam logic [1:0] ST_I_WAIT = 2'd3;

  // Backing-memory requester select
  localparam logic SEL_IREFILL = 1'b0;
  localparam logic SEL_DACCESS = 1'b1;

  // Load in EX whose destination feeds the instruction in ID; r0 never hazards
  function automatic logic is_load_use(input logic       idex_memread,
                                       input logic [4:0] idex_rt,
                                       input logic [4:0] ifid_rs,
                                       input logic [4:0] ifid_rt);
    return idex_memread && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// rtl/mem_stall_ctrl_if.sv - pipeline/memory signal bundle for the stall controller
interface mem_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             mem_read;
  logic             mem_write;
  logic             dcache_hit;
  logic             icache_hit;
  logic             if_valid;
  logic             mem_ready;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_bubble;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel;
  logic [CNT_W-1:0] dstall_cnt;
  logic [CNT_W-1:0] istall_cnt;

  // Controller side
  modport slave (
    input  mem_read, mem_write, dcache_hit, icache_hit, if_valid, mem_ready,
           idex_memread, idex_rt, ifid_rs, ifid_rt,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_bubble, idex_bubble, memwb_bubble,
           mem_req, mem_we, mem_sel, dstall_cnt, istall_cnt
  );

  // Pipeline / memory side
  modport master (
    output mem_read, mem_write, dcache_hit, icache_hit, if_valid, mem_ready,
           idex_memread, idex_rt, ifid_rs, ifid_rt,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_bubble, idex_bubble, memwb_bubble,
           mem_req, mem_we, mem_sel, dstall_cnt, istall_cnt
  );
endinterface

// File: rtl/mem_stall_ctrl_sat_counter.sv
// rtl/mem_stall_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared immediately by reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - pipeline stall/bubble control for cache misses and load-use hazards
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clock,
  input logic               rst,
  mem_stall_ctrl_if.slave   bus
);

  logic [1:0] state_q, state_d;
  logic       mem_we_q, mem_we_d;
  logic       d_need, i_need, load_use;
  logic       dinc, iinc;

  // Stores always go to memory (write-through); loads only on a miss
  assign d_need   = (bus.mem_read & ~bus.dcache_hit) | bus.mem_write;
  assign i_need   = bus.if_valid & ~bus.icache_hit;
  assign load_use = is_load_use(bus.idex_memread, bus.idex_rt, bus.ifid_rs, bus.ifid_rt);

  // Stall decode and next state; reset forces the free-running defaults
  always_comb begin
    state_d          = state_q;
    mem_we_d         = mem_we_q;
    dinc             = 1'b0;
    iinc             = 1'b0;
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.idex_write   = 1'b1;
    bus.exmem_write  = 1'b1;
    bus.ifid_bubble  = 1'b0;
    bus.idex_bubble  = 1'b0;
    bus.memwb_bubble = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_sel      = SEL_IREFILL;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (d_need) begin
            state_d  = ST_D_WAIT;
            mem_we_d = bus.mem_write;
            dinc     = 1'b1;
          end else if (i_need) begin
            state_d  = ST_I_WAIT;
            iinc     = 1'b1;
          end else if (load_use) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end
        end
        ST_D_WAIT: begin
          bus.mem_req = 1'b1;
          bus.mem_sel = SEL_DACCESS;
          bus.mem_we  = mem_we_q;
          dinc        = 1'b1;
          if (bus.mem_ready) state_d = ST_D_DONE;
        end
        ST_D_DONE: begin
          state_d = ST_RUN;
        end
        default: begin
          // I-refill in flight; a data miss here only freezes the back end
          bus.mem_req = 1'b1;
          bus.mem_sel = SEL_IREFILL;
          iinc        = 1'b1;
          dinc        = d_need;
          if (bus.mem_ready) state_d = ST_RUN;
        end
      endcase
      if (iinc) begin
        bus.pc_write    = 1'b0;
        bus.ifid_bubble = 1'b1;
      end
      if (dinc) begin
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.idex_write   = 1'b0;
        bus.exmem_write  = 1'b0;
        bus.memwb_bubble = 1'b1;
      end
    end
  end

  // Controller state and latched store flag
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_dstall (
    .clock   (clock),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (dinc),
    .cnt_o   (bus.dstall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_istall (
    .clock   (clock),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (iinc),
    .cnt_o   (bus.istall_cnt)
  );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - scoreboard bench for the memory stall controller
module tb_mem_stall_ctrl;

  localparam int CNT_W = 16;
  localparam int SAT   = 65535;
  localparam int M_RUN = 0, M_DW = 1, M_DD = 2, M_IW = 3;
  // {pc,ifid,idex,exmem, ifid_b,idex_b,memwb_b, req,we,sel}
  localparam logic [9:0] V_FREE = 10'b1111_000_000;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  mem_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mem_stall_ctrl #(.CNT_W(CNT_W)) dut (.clock(clock), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct { logic [9:0] v; int dc; int ic; } exp_t;
  exp_t sb[$];

  int m_st, m_dc, m_ic;
  bit m_we;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
            bus.ifid_bubble, bus.idex_bubble, bus.memwb_bubble,
            bus.mem_req, bus.mem_we, bus.mem_sel};
  endfunction

  function automatic logic [9:0] model_out(bit dn, bit in_, bit lu);
    case (m_st)
      M_RUN: begin
        if (dn)       return 10'b0000_001_000;
        else if (in_) return 10'b0111_100_000;
        else if (lu)  return 10'b0011_010_000;
        else          return V_FREE;
      end
      M_DW:    return {7'b0000_001, 1'b1, m_we, 1'b1};
      M_DD:    return V_FREE;
      default: return dn ? 10'b0000_101_100 : 10'b0111_100_100;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_RUN; m_we = 1'b0; m_dc = 0; m_ic = 0;
  endtask

  task automatic model_step(bit dn, bit in_, bit mw, bit rdy);
    bit fs, is;
    fs = (m_st == M_RUN && dn) || (m_st == M_DW) || (m_st == M_IW && dn);
    is = (m_st == M_RUN && !dn && in_) || (m_st == M_IW);
    if (fs && m_dc < SAT) m_dc++;
    if (is && m_ic < SAT) m_ic++;
    case (m_st)
      M_RUN: if (dn) begin m_st = M_DW; m_we = mw; end else if (in_) m_st = M_IW;
      M_DW:  if (rdy) m_st = M_DD;
      M_DD:  m_st = M_RUN;
      default: if (rdy) m_st = M_RUN;
    endcase
  endtask

  task automatic clr_inputs();
    bus.mem_read = 0; bus.mem_write = 0; bus.dcache_hit = 0; bus.icache_hit = 0;
    bus.if_valid = 0; bus.mem_ready = 0; bus.idex_memread = 0;
    bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
  endtask

  // One clock: drive at negedge, push expectation, sample 2ns later, advance model at posedge
  task automatic cyc(input string tag, input bit mr, input bit mw, input bit dh,
                     input bit ifv, input bit ih, input bit rdy,
                     input bit idm = 0, input int rt = 0, input int rs = 0, input int rtt = 0);
    exp_t e;
    bit dn, in_, lu;
    @(negedge clock);
    bus.mem_read = mr; bus.mem_write = mw; bus.dcache_hit = dh;
    bus.if_valid = ifv; bus.icache_hit = ih; bus.mem_ready = rdy;
    bus.idex_memread = idm; bus.idex_rt = 5'(rt); bus.ifid_rs = 5'(rs); bus.ifid_rt = 5'(rtt);
    dn  = (mr && !dh) || mw;
    in_ = ifv && !ih;
    lu  = idm && (rt != 0) && (rt == rs || rt == rtt);
    e.v = model_out(dn, in_, lu); e.dc = m_dc; e.ic = m_ic;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check_val({tag, ".out"}, 32'(obs_vec()), 32'(e.v));
    check_val({tag, ".dcnt"}, 32'(bus.dstall_cnt), 32'(e.dc));
    check_val({tag, ".icnt"}, 32'(bus.istall_cnt), 32'(e.ic));
    @(posedge clock);
    model_step(dn, in_, mw, rdy);
  endtask

  int d0, i0;

  initial begin
    clr_inputs();
    model_reset();
    // Reset: defaults even with a pending data miss on the inputs
    repeat (2) @(negedge clock);
    bus.mem_write = 1;
    #1;
    check_val("rst.out", 32'(obs_vec()), 32'(V_FREE));
    check_val("rst.dcnt", 32'(bus.dstall_cnt), 32'd0);
    check_val("rst.icnt", 32'(bus.istall_cnt), 32'd0);
    clr_inputs();
    @(negedge clock);
    rst = 1'b0;

    cyc("idle", 0, 0, 0, 0, 0, 0);
    cyc("rdy_run", 0, 0, 0, 0, 0, 1);

    // Load miss, memory answers in the 4th wait cycle
    d0 = m_dc;
    cyc("ld_in", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("ld_wait", 1, 0, 0, 0, 0, 0);
    cyc("ld_rdy", 1, 0, 0, 0, 0, 1);
    cyc("ld_done", 1, 0, 0, 0, 0, 0);
    check_val("ld_stalls", 32'(bus.dstall_cnt), 32'(d0 + 5));
    check_val("ld_const", 32'(bus.dstall_cnt), 32'd5);
    cyc("ld_after", 0, 0, 0, 0, 0, 0);

    // Store hit goes write-through
    cyc("st_in", 0, 1, 1, 0, 0, 0);
    cyc("st_w1", 0, 1, 1, 0, 0, 0);
    cyc("st_w2", 0, 1, 1, 0, 0, 1);
    cyc("st_done", 0, 1, 1, 0, 0, 0);
    cyc("st_after", 0, 0, 0, 0, 0, 0);

    // Load-use hazards
    cyc("lu_rs", 0, 0, 0, 0, 0, 0, 1, 8, 8, 3);
    cyc("lu_rt", 0, 0, 0, 0, 0, 0, 1, 9, 2, 9);
    cyc("lu_r0", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("lu_nom", 0, 0, 0, 0, 0, 0, 1, 8, 7, 6);
    cyc("lu_ihit", 0, 0, 0, 1, 1, 0, 1, 8, 8, 0);

    // Simultaneous D and I miss: D first, then I refill
    d0 = m_dc; i0 = m_ic;
    cyc("di_in", 1, 0, 0, 1, 0, 0);
    cyc("di_dw", 1, 0, 0, 1, 0, 0);
    cyc("di_drdy", 1, 0, 0, 1, 0, 1);
    cyc("di_dd", 0, 0, 0, 1, 0, 0);
    cyc("di_iin", 0, 0, 0, 1, 0, 0);
    cyc("di_iw", 0, 0, 0, 1, 0, 0);
    cyc("di_irdy", 0, 0, 0, 1, 0, 1);
    cyc("di_run", 0, 0, 0, 0, 0, 0);
    check_val("di_dcnt", 32'(bus.dstall_cnt - d0), 32'd3);
    check_val("di_icnt", 32'(bus.istall_cnt - i0), 32'd3);

    // Data miss arising during I refill waits for RUN
    cyc("id_iin", 0, 0, 0, 1, 0, 0);
    cyc("id_iw_d", 0, 1, 0, 1, 0, 0);
    cyc("id_irdy", 0, 1, 0, 1, 0, 1);
    cyc("id_din", 0, 1, 0, 0, 0, 0);
    cyc("id_drdy", 0, 1, 0, 0, 0, 1);
    cyc("id_dd", 0, 1, 0, 0, 0, 0);
    cyc("id_run", 0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a data wait
    cyc("rs_in", 0, 1, 0, 0, 0, 0);
    cyc("rs_dw", 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    rst = 1'b1;
    #1;
    check_val("rs_req", 32'(bus.mem_req), 32'd0);
    check_val("rs_out", 32'(obs_vec()), 32'(V_FREE));
    check_val("rs_dcnt", 32'(bus.dstall_cnt), 32'd0);
    check_val("rs_icnt", 32'(bus.istall_cnt), 32'd0);
    clr_inputs();
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    cyc("rs_run", 0, 0, 0, 0, 0, 0);
    cyc("rs_iin", 0, 0, 0, 1, 0, 0);
    cyc("rs_irdy", 0, 0, 0, 1, 0, 1);

    // Long data wait drives the stall counter into saturation
    for (int k = 0; k < 70000; k++) cyc("sat", 0, 1, 0, 0, 0, 0);
    check_val("sat_hold", 32'(bus.dstall_cnt), 32'(SAT));
    cyc("sat_rdy", 0, 1, 0, 0, 0, 1);
    cyc("sat_dd", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating stall counters.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have ports mem_read and mem_write, inputs, 1 each, EX/MEM-stage memory control bits.
REQ-005 SHALL have ports dcache_hit and icache_hit, inputs, 1 each, same-cycle cache lookup results.
REQ-006 SHALL have port if_valid, input, 1, IF stage is fetching.
REQ-007 SHALL have port mem_ready, input, 1, backing memory one-cycle completion pulse.
REQ-008 SHALL have ports idex_memread (input, 1), idex_rt (input, 5), ifid_rs (input, 5) and ifid_rt (input, 5), for load-use detection.
REQ-009 SHALL have outputs pc_write, ifid_write, idex_write and exmem_write, 1 each, pipeline register write enables.
REQ-010 SHALL have outputs ifid_bubble, idex_bubble and memwb_bubble, 1 each, NOP insertion.
REQ-011 SHALL have outputs mem_req, mem_we and mem_sel (0=I-refill, 1=D-access), 1 each, backing-memory request.
REQ-012 SHALL have outputs dstall_cnt and istall_cnt, CNT_W each, stall-cycle performance counters.

Function
REQ-013 SHALL implement FSM states RUN, D_WAIT, D_DONE, I_WAIT.
REQ-014 SHALL define d_need = (mem_read & ~dcache_hit) | mem_write (stores are write-through); i_need = if_valid & ~icache_hit.
REQ-015 RUN with d_need SHALL go to D_WAIT, latch mem_we_q=mem_write, and assert full stall in that same cycle.
REQ-016 Full stall SHALL mean pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1.
REQ-017 D_WAIT SHALL drive mem_req=1, mem_sel=1, mem_we=mem_we_q, full stall; on mem_ready=1 it SHALL go to D_DONE.
REQ-018 D_DONE SHALL last exactly one cycle: all enables 1, no bubbles, mem_req=0, d_need ignored; next state RUN.
REQ-019 RUN with ~d_need and i_need SHALL go to I_WAIT; that cycle and every I_WAIT cycle SHALL drive pc_write=0, ifid_write=1, ifid_bubble=1, back stages enabled.
REQ-020 I_WAIT SHALL drive mem_req=1, mem_sel=0, mem_we=0; on mem_ready=1 it SHALL go to RUN.
REQ-021 d_need arising in I_WAIT SHALL add full stall without a state change; D service SHALL start from RUN after I completion (D priority applies only in RUN).
REQ-022 Simultaneous d_need and i_need in RUN SHALL select D_WAIT.
REQ-023 Load-use SHALL be detected as idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
REQ-024 Load-use, only in RUN with ~d_need & ~i_need, SHALL drive pc_write=0, ifid_write=0, idex_bubble=1 for that cycle.
REQ-025 With no hazard in RUN, all enables SHALL be 1, bubbles 0, mem_req=0.
REQ-026 dstall_cnt SHALL increment on each full-stall cycle; istall_cnt SHALL increment on each I_WAIT/I-entry cycle; both SHALL saturate at all-ones.
REQ-027 mem_ready outside D_WAIT/I_WAIT SHALL be ignored.
REQ-028 Stall/enable outputs SHALL be combinational from state and inputs; state, mem_we_q and counters SHALL be registered.

Reset
REQ-029 rst SHALL force state=RUN, mem_we_q=0 and counters=0 immediately, aborting any outstanding request (mem_req drops asynchronously).
REQ-030 While rst=1, outputs SHALL be: all enables 1, all bubbles 0, mem_req=0, mem_we=0, mem_sel=0.

Structure
REQ-031 State encoding and the mem_sel encoding SHALL live in the shared pipeline package.
REQ-032 A single sub-module sat_counter (CNT_W-wide, inc, clear) SHALL be instantiated twice.

Verification
REQ-033 Load miss: mem_read=1, dcache_hit=0, mem_ready after 4 cycles -> exmem_write=0 for 5 cycles, D_DONE one cycle, dstall_cnt=5.
REQ-034 Store hit: mem_write=1, dcache_hit=1, mem_ready on the 2nd D_WAIT cycle -> mem_we=1, mem_sel=1, store retires in D_DONE, no repeat request.
REQ-035 Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> one cycle pc_write=0, idex_bubble=1; repeat with idex_rt=0 -> no stall.
REQ-036 Simultaneous D and I miss -> mem_sel=1 first; after D_DONE, I_WAIT with mem_sel=0; istall_cnt counts only I cycles.
REQ-037 rst pulse in the middle of D_WAIT -> mem_req=0 in the same cycle, counters 0, RUN after release.
REQ-038 Force 70000 stall cycles with CNT_W=16 -> dstall_cnt holds at 65535.
